regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file in the RV32IM pipeline.
- Arbitrates that port between two sources:
  - the pipeline writeback stage (WB), which has fixed priority;
  - the multi-cycle mul/div unit (MD), whose results are held in a small FIFO.
- Keeps a busy scoreboard of MD destination registers and raises hazard/stall signals to the decode stage.

---
 rtl/regfile_wb_arbiter_if.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
// Bundles every non-clock/reset signal of the register-file write-port
// arbiter.
//   slave  : view used by the arbiter. Pipeline WB, mul/div issue/result and
//            decode operands are inputs; MD_READY, HAZARD, WB_STALL and the
//            register-file write port are outputs.
//   master : mirror view for whoever drives the arbiter (pipeline / bench).
interface regfile_wb_arbiter_if;
  logic        WB_EN;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;
  logic        MD_ISSUE;
  logic [4:0]  MD_ISSUE_ADDR;
  logic        MD_VALID;
  logic [4:0]  MD_ADDR;
  logic [31:0] MD_DATA;
  logic        MD_READY;
  logic [4:0]  RS1_ADDR;
  logic [4:0]  RS2_ADDR;
  logic [4:0]  RD_ADDR;
  logic        HAZARD;
  logic        WB_STALL;
  logic        WRITE_EN;
  logic [4:0]  WRITE_ADDR;
  logic [31:0] WRITE_DATA;

  modport slave (
    input  WB_EN, WB_ADDR, WB_DATA,
    input  MD_ISSUE, MD_ISSUE_ADDR,
    input  MD_VALID, MD_ADDR, MD_DATA,
    output MD_READY,
    input  RS1_ADDR, RS2_ADDR, RD_ADDR,
    output HAZARD, WB_STALL,
    output WRITE_EN, WRITE_ADDR, WRITE_DATA
  );

  modport master (
    output WB_EN, WB_ADDR, WB_DATA,
    output MD_ISSUE, MD_ISSUE_ADDR,
    output MD_VALID, MD_ADDR, MD_DATA,
    input  MD_READY,
    output RS1_ADDR, RS2_ADDR, RD_ADDR,
    input  HAZARD, WB_STALL,
    input  WRITE_EN, WRITE_ADDR, WRITE_DATA
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Owns the single write port of the 32x32 register file. Writeback (WB) has
// fixed priority; mul/div (MD) results queue in a DEPTH-entry FIFO and drain
// whenever WB is idle or after STARVE_MAX consecutive blocked cycles, when a
// one-cycle WB bubble (WB_STALL) is forced. A busy scoreboard of outstanding
// MD destinations drives HAZARD back to decode.
// Ports:
//   CLK      : clock, all state updates on posedge
//   RESET_N  : synchronous active-low reset; also forces outputs quiet
//   bus      : regfile_wb_arbiter_if.slave (WB, MD issue/result, decode
//              operands, MD_READY, HAZARD, WB_STALL, register-file write port)
module regfile_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  regfile_wb_arbiter_if.slave   bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX) + 1;

  // FIFO entry: {rd, data}
  logic [36:0]   fifo_q [DEPTH];
  logic [36:0]   fifo_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   busy_q, busy_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          wb_stall_q, wb_stall_d;

  logic          nonempty_s;
  logic          md_ready_s;
  logic          push_s;
  logic          wb_win_s;
  logic          pop_s;
  logic [4:0]    head_addr_s;
  logic [31:0]   head_data_s;
  logic [4:0]    sel_addr_s;
  logic [31:0]   sel_data_s;

  // Port arbitration and FIFO handshake decode.
  always_comb begin
    nonempty_s  = (count_q != {CW{1'b0}});
    md_ready_s  = RESET_N & (count_q != CW'(DEPTH));
    push_s      = bus.MD_VALID & md_ready_s;
    // A stalled cycle never lets WB win, so a stray WB_EN is dropped.
    wb_win_s    = bus.WB_EN & ~wb_stall_q;
    pop_s       = ~wb_win_s & nonempty_s;
    head_addr_s = fifo_q[rptr_q][36:32];
    head_data_s = fifo_q[rptr_q][31:0];
    if (wb_win_s) begin
      sel_addr_s = bus.WB_ADDR;
      sel_data_s = bus.WB_DATA;
    end else if (pop_s) begin
      sel_addr_s = head_addr_s;
      sel_data_s = head_data_s;
    end else begin
      sel_addr_s = 5'd0;
      sel_data_s = 32'd0;
    end
  end

  // Outputs; x0 writes are suppressed but an x0 head still pops.
  always_comb begin
    bus.MD_READY   = md_ready_s;
    bus.WB_STALL   = RESET_N & wb_stall_q;
    bus.WRITE_EN   = RESET_N & (wb_win_s | pop_s) & (sel_addr_s != 5'd0);
    bus.WRITE_ADDR = sel_addr_s;
    bus.WRITE_DATA = sel_data_s;
    bus.HAZARD     = RESET_N & ((busy_q[bus.RS1_ADDR] & (bus.RS1_ADDR != 5'd0)) |
                                (busy_q[bus.RS2_ADDR] & (bus.RS2_ADDR != 5'd0)) |
                                (busy_q[bus.RD_ADDR]  & (bus.RD_ADDR  != 5'd0)));
  end

  // Next-state for FIFO, scoreboard and starvation counter.
  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_s) begin
      fifo_d[wptr_q] = {bus.MD_ADDR, bus.MD_DATA};
      wptr_d         = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Clear first so a same-cycle issue to the popped rd leaves it busy.
    busy_d = busy_q;
    if (pop_s) begin
      busy_d[head_addr_s] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (bus.MD_ISSUE) begin
      busy_d[bus.MD_ISSUE_ADDR] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;

    // Stall fires on the STARVE_MAX-th consecutive blocked cycle.
    if (nonempty_s & wb_win_s) begin
      if (starve_q == SW'(STARVE_MAX - 1)) begin
        starve_d   = {SW{1'b0}};
        wb_stall_d = 1'b1;
      end else begin
        starve_d   = starve_q + SW'(1);
        wb_stall_d = 1'b0;
      end
    end else begin
      starve_d   = {SW{1'b0}};
      wb_stall_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      fifo_q     <= '{default: 37'd0};
      wptr_q     <= {PW{1'b0}};
      rptr_q     <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      busy_q     <= 32'd0;
      starve_q   <= {SW{1'b0}};
      wb_stall_q <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      starve_q   <= starve_d;
      wb_stall_q <= wb_stall_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Directed scenarios from the block's behaviour plus a randomized run checked
// against a queue-based reference model of the arbiter.
module tb_regfile_wb_arbiter;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t        mq[$];
  bit [31:0]   m_busy;
  int          m_starve;
  bit          m_stall;

  logic        exp_ready, exp_stall, exp_wen, exp_haz;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  function automatic void model_eval();
    bit wb_win;
    bit pop;
    wb_win    = bus.WB_EN && !m_stall;
    pop       = !wb_win && (mq.size() > 0);
    exp_ready = RESET_N && (mq.size() < DEPTH);
    exp_stall = RESET_N && m_stall;
    exp_addr  = 5'd0;
    exp_data  = 32'd0;
    if (wb_win) begin
      exp_addr = bus.WB_ADDR;
      exp_data = bus.WB_DATA;
    end else if (pop) begin
      exp_addr = mq[0].a;
      exp_data = mq[0].d;
    end
    exp_wen = RESET_N && (wb_win || pop) && (exp_addr != 5'd0);
    exp_haz = RESET_N && ((bus.RS1_ADDR != 5'd0 && m_busy[bus.RS1_ADDR]) ||
                          (bus.RS2_ADDR != 5'd0 && m_busy[bus.RS2_ADDR]) ||
                          (bus.RD_ADDR  != 5'd0 && m_busy[bus.RD_ADDR]));
  endfunction

  function automatic void model_update();
    bit had;
    bit wb_win;
    bit pop;
    bit push;
    if (!RESET_N) begin
      mq.delete();
      m_busy   = 32'd0;
      m_starve = 0;
      m_stall  = 1'b0;
    end else begin
      had    = mq.size() > 0;
      wb_win = bus.WB_EN && !m_stall;
      pop    = !wb_win && had;
      push   = bus.MD_VALID && (mq.size() < DEPTH);
      if (pop) begin
        m_busy[mq[0].a] = 1'b0;
        void'(mq.pop_front());
      end
      if (bus.MD_ISSUE && bus.MD_ISSUE_ADDR != 5'd0) m_busy[bus.MD_ISSUE_ADDR] = 1'b1;
      if (push) mq.push_back({bus.MD_ADDR, bus.MD_DATA});
      if (had && wb_win) begin
        if (m_starve == STARVE_MAX - 1) begin
          m_stall  = 1'b1;
          m_starve = 0;
        end else begin
          m_starve = m_starve + 1;
          m_stall  = 1'b0;
        end
      end else begin
        m_starve = 0;
        m_stall  = 1'b0;
      end
    end
  endfunction

  // Advance one clock: model follows the same inputs, return at negedge.
  task automatic tick();
    model_update();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    bus.WB_EN = 1'b0;        bus.WB_ADDR = 5'd0;       bus.WB_DATA = 32'd0;
    bus.MD_ISSUE = 1'b0;     bus.MD_ISSUE_ADDR = 5'd0;
    bus.MD_VALID = 1'b0;     bus.MD_ADDR = 5'd0;       bus.MD_DATA = 32'd0;
    bus.RS1_ADDR = 5'd0;     bus.RS2_ADDR = 5'd0;      bus.RD_ADDR = 5'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    bus.WB_EN = 1'b1; bus.WB_ADDR = 5'd10; bus.WB_DATA = 32'h1234_5678;
    bus.MD_ISSUE = 1'b1; bus.MD_ISSUE_ADDR = 5'd5;
    bus.MD_VALID = 1'b1; bus.MD_ADDR = 5'd3; bus.MD_DATA = 32'h0000_0003;
    tick();
    bus.MD_ISSUE = 1'b0;
    bus.MD_ADDR = 5'd4; bus.MD_DATA = 32'h0000_0004;
    tick();
    bus.MD_VALID = 1'b0; bus.RS1_ADDR = 5'd5;
    #1;
    checks++; if (bus.MD_READY !== 1'b0) begin errors++; $display("FAIL reset_prefill_full: MD_READY=%b want 0", bus.MD_READY); end
    checks++; if (bus.HAZARD !== 1'b1) begin errors++; $display("FAIL reset_prefill_busy5: HAZARD=%b want 1", bus.HAZARD); end
    RESET_N = 1'b0; bus.WB_EN = 1'b0;
    #1;
    checks++; if ({bus.WRITE_EN, bus.MD_READY, bus.HAZARD, bus.WB_STALL} !== 4'b0000) begin
      errors++; $display("FAIL reset_forced_outputs: WE/RDY/HZ/ST=%b want 0000",
                         {bus.WRITE_EN, bus.MD_READY, bus.HAZARD, bus.WB_STALL});
    end
    tick();
    tick();
    RESET_N = 1'b1;
    #1;
    checks++; if (bus.MD_READY !== 1'b1) begin errors++; $display("FAIL reset_md_ready: MD_READY=%b want 1", bus.MD_READY); end
    checks++; if (bus.HAZARD !== 1'b0) begin errors++; $display("FAIL reset_busy_cleared: HAZARD=%b want 0", bus.HAZARD); end
    checks++; if (bus.WRITE_EN !== 1'b0) begin errors++; $display("FAIL reset_fifo_empty: WRITE_EN=%b want 0", bus.WRITE_EN); end
    tick();
  endtask

  task automatic test_idle_drain();
    do_reset();
    bus.MD_ISSUE = 1'b1; bus.MD_ISSUE_ADDR = 5'd7;
    tick();
    bus.MD_ISSUE = 1'b0; bus.RS1_ADDR = 5'd7;
    bus.MD_VALID = 1'b1; bus.MD_ADDR = 5'd7; bus.MD_DATA = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.HAZARD !== 1'b1) begin errors++; $display("FAIL idle_hazard_set: HAZARD=%b want 1", bus.HAZARD); end
    checks++; if (bus.WRITE_EN !== 1'b0) begin errors++; $display("FAIL idle_no_same_cycle_write: WRITE_EN=%b want 0", bus.WRITE_EN); end
    tick();
    bus.MD_VALID = 1'b0;
    #1;
    checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b1, 5'd7, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL idle_drain_write: en=%b addr=%0d data=%h want en=1 addr=7 data=deadbeef",
                         bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA);
    end
    tick();
    #1;
    checks++; if (bus.HAZARD !== 1'b0) begin errors++; $display("FAIL idle_hazard_clear: HAZARD=%b want 0", bus.HAZARD); end
    tick();
  endtask

  task automatic test_wb_priority();
    do_reset();
    bus.WB_EN = 1'b1; bus.WB_ADDR = 5'd10; bus.WB_DATA = 32'hA5A5_0010;
    bus.MD_VALID = 1'b1; bus.MD_ADDR = 5'd3; bus.MD_DATA = 32'h3333_3333;
    #1;
    checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b1, 5'd10, 32'hA5A5_0010}) begin
      errors++; $display("FAIL wbprio_wb_write0: en=%b addr=%0d data=%h want 1/10/a5a50010",
                         bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA);
    end
    tick();
    bus.MD_ADDR = 5'd4; bus.MD_DATA = 32'h4444_4444;
    tick();
    bus.MD_ADDR = 5'd6; bus.MD_DATA = 32'h6666_6666;
    #1;
    checks++; if (bus.MD_READY !== 1'b0) begin errors++; $display("FAIL wbprio_full: MD_READY=%b want 0", bus.MD_READY); end
    checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR} !== {1'b1, 5'd10}) begin
      errors++; $display("FAIL wbprio_wb_write2: en=%b addr=%0d want 1/10", bus.WRITE_EN, bus.WRITE_ADDR);
    end
    tick();
    bus.WB_EN = 1'b0;
    #1;
    checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b1, 5'd3, 32'h3333_3333}) begin
      errors++; $display("FAIL wbprio_pop_rd3: en=%b addr=%0d data=%h want 1/3/33333333",
                         bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA);
    end
    checks++; if (bus.MD_READY !== 1'b0) begin errors++; $display("FAIL wbprio_full_pop_refuse: MD_READY=%b want 0", bus.MD_READY); end
    tick();
    #1;
    checks++; if ({bus.WRITE_ADDR, bus.WRITE_DATA} !== {5'd4, 32'h4444_4444}) begin
      errors++; $display("FAIL wbprio_pop_rd4: addr=%0d data=%h want 4/44444444", bus.WRITE_ADDR, bus.WRITE_DATA);
    end
    tick();
    bus.MD_VALID = 1'b0;
    #1;
    checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b1, 5'd6, 32'h6666_6666}) begin
      errors++; $display("FAIL wbprio_held_rd6: en=%b addr=%0d data=%h want 1/6/66666666",
                         bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA);
    end
    tick();
  endtask

  task automatic test_starvation();
    do_reset();
    bus.WB_EN = 1'b1; bus.WB_ADDR = 5'd1; bus.WB_DATA = 32'h0000_00A1;
    bus.MD_VALID = 1'b1; bus.MD_ADDR = 5'd12; bus.MD_DATA = 32'hC0DE_000C;
    tick();
    bus.MD_VALID = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= STARVE_MAX; k++) begin
        bus.WB_EN = 1'b1;
        #1;
        checks++; if ({bus.WB_STALL, bus.WRITE_ADDR} !== {1'b0, 5'd1}) begin
          errors++; $display("FAIL starve_blocked_r%0d_c%0d: stall=%b addr=%0d want 0/1", r, k, bus.WB_STALL, bus.WRITE_ADDR);
        end
        tick();
      end
      bus.WB_EN = 1'b0;
      bus.MD_VALID = (r == 0);
      bus.MD_ADDR = 5'd13; bus.MD_DATA = 32'hC0DE_000D;
      #1;
      checks++; if (bus.WB_STALL !== 1'b1) begin errors++; $display("FAIL starve_stall_r%0d: WB_STALL=%b want 1", r, bus.WB_STALL); end
      checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !==
                    {1'b1, (r == 0) ? 5'd12 : 5'd13, (r == 0) ? 32'hC0DE_000C : 32'hC0DE_000D}) begin
        errors++; $display("FAIL starve_drain_r%0d: en=%b addr=%0d data=%h", r, bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA);
      end
      tick();
      bus.MD_VALID = 1'b0;
    end
    #1;
    checks++; if ({bus.WB_STALL, bus.WRITE_EN} !== 2'b00) begin
      errors++; $display("FAIL starve_stall_one_cycle: stall/en=%b want 00", {bus.WB_STALL, bus.WRITE_EN});
    end
    tick();
  endtask

  task automatic test_x0_collisions();
    do_reset();
    bus.MD_VALID = 1'b1; bus.MD_ADDR = 5'd0; bus.MD_DATA = 32'h0BAD_0000;
    tick();
    bus.MD_ADDR = 5'd8; bus.MD_DATA = 32'h8888_0008;
    bus.MD_ISSUE = 1'b1; bus.MD_ISSUE_ADDR = 5'd9;
    #1;
    checks++; if (bus.WRITE_EN !== 1'b0) begin errors++; $display("FAIL x0_suppressed: WRITE_EN=%b want 0", bus.WRITE_EN); end
    tick();
    bus.MD_ISSUE = 1'b0;
    bus.MD_ADDR = 5'd9; bus.MD_DATA = 32'h9999_0009;
    #1;
    checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b1, 5'd8, 32'h8888_0008}) begin
      errors++; $display("FAIL x0_popped_then_rd8: en=%b addr=%0d data=%h want 1/8/88880008",
                         bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA);
    end
    checks++; if (bus.MD_READY !== 1'b1) begin errors++; $display("FAIL pushpop_ready: MD_READY=%b want 1", bus.MD_READY); end
    tick();
    bus.MD_VALID = 1'b0;
    bus.MD_ISSUE = 1'b1; bus.MD_ISSUE_ADDR = 5'd9; bus.RS1_ADDR = 5'd9;
    #1;
    checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b1, 5'd9, 32'h9999_0009}) begin
      errors++; $display("FAIL pushpop_no_loss: en=%b addr=%0d data=%h want 1/9/99990009",
                         bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA);
    end
    tick();
    bus.MD_ISSUE = 1'b0;
    #1;
    checks++; if (bus.HAZARD !== 1'b1) begin errors++; $display("FAIL set_clear_collision: HAZARD=%b want 1", bus.HAZARD); end
    checks++; if (bus.WRITE_EN !== 1'b0) begin errors++; $display("FAIL pushpop_count_empty: WRITE_EN=%b want 0", bus.WRITE_EN); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      RESET_N           = ($urandom_range(0, 79) != 0);
      bus.WB_EN         = ($urandom_range(0, 9) < 6) && !(m_stall && $urandom_range(0, 3) != 0);
      bus.WB_ADDR       = 5'($urandom_range(0, 31));
      bus.WB_DATA       = $urandom;
      bus.MD_ISSUE      = ($urandom_range(0, 2) == 0);
      bus.MD_ISSUE_ADDR = 5'($urandom_range(0, 15));
      bus.MD_VALID      = ($urandom_range(0, 2) != 0);
      bus.MD_ADDR       = 5'($urandom_range(0, 15));
      bus.MD_DATA       = $urandom;
      bus.RS1_ADDR      = 5'($urandom_range(0, 15));
      bus.RS2_ADDR      = 5'($urandom_range(0, 15));
      bus.RD_ADDR       = 5'($urandom_range(0, 15));
      #1;
      model_eval();
      checks++; if (bus.MD_READY !== exp_ready) begin errors++; $display("FAIL rand_md_ready[%0d]: got %b want %b", i, bus.MD_READY, exp_ready); end
      checks++; if (bus.WB_STALL !== exp_stall) begin errors++; $display("FAIL rand_wb_stall[%0d]: got %b want %b", i, bus.WB_STALL, exp_stall); end
      checks++; if (bus.HAZARD !== exp_haz) begin errors++; $display("FAIL rand_hazard[%0d]: got %b want %b", i, bus.HAZARD, exp_haz); end
      checks++; if (bus.WRITE_EN !== exp_wen) begin errors++; $display("FAIL rand_write_en[%0d]: got %b want %b", i, bus.WRITE_EN, exp_wen); end
      if (exp_wen) begin
        checks++; if ({bus.WRITE_ADDR, bus.WRITE_DATA} !== {exp_addr, exp_data}) begin
          errors++; $display("FAIL rand_write_port[%0d]: got %0d/%h want %0d/%h", i, bus.WRITE_ADDR, bus.WRITE_DATA, exp_addr, exp_data);
        end
      end
      tick();
    end
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N  = 1'b0;
    m_busy   = 32'd0;
    m_starve = 0;
    m_stall  = 1'b0;
    clear_inputs();
    test_reset();
    test_idle_drain();
    test_wb_priority();
    test_starvation();
    test_x0_collisions();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
